// File: rtl/bitty_pkg.sv
// bitty_pkg: shared encodings for the bitty execute core.
//   - instruction type codes, ALU select codes
//   - FSM state encoding
//   - instruction field bit positions
package bitty_pkg;

  typedef enum logic [1:0] {
    TYPE_REG = 2'b00,
    TYPE_IMM = 2'b01,
    TYPE_BR  = 2'b10,
    TYPE_RSV = 2'b11
  } itype_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_CMP = 3'd7;

  typedef enum logic [2:0] {
    WAIT0  = 3'd0,
    WAIT1  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    DONE   = 3'd5
  } state_e;

  // Instruction field positions (LSB) and widths
  localparam int RX_LSB   = 13;
  localparam int RY_LSB   = 10;
  localparam int REG_W    = 3;
  localparam int IMM_LSB  = 5;
  localparam int IMM_W    = 8;
  localparam int SEL_LSB  = 2;
  localparam int SEL_W    = 3;
  localparam int TYPE_LSB = 0;
  localparam int TYPE_W   = 2;

endpackage

// File: rtl/bitty_alu.sv
// bitty_alu: combinational ALU for the bitty execute core.
//   a, b : operands (b is the register Ry or the zero-extended imm8)
//   sel  : operation select (ALU_ADD..ALU_CMP)
//   y    : result, mod 2^W; cmp yields 0 (eq), 1 (a>b), 2 (a<b), unsigned
module bitty_alu
  import bitty_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (sel)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SHL: y = a << b[3:0];
      ALU_SHR: y = a >> b[3:0];
      ALU_CMP: begin
        if (a == b)     y = '0;
        else if (a > b) y = W'(1);
        else            y = W'(2);
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/bitty_exec_core.sv
// bitty_exec_core: execute side of the bitty fetch/execute handshake.
//   clk             : rising-edge clock
//   reset           : synchronous active-low reset
//   instruction_in  : instruction from the fetch unit's output register
//   done1           : 1-cycle pulse, last_alu_result final for this instruction
//   done2           : 1-cycle pulse the cycle after done1, advances the PC
//   last_alu_result : result of the most recent ALU/immediate instruction
//   dbg_sel/dbg_data: combinational register-file read port
// Each instruction takes FETCH_WAIT+4 cycles: WAIT0, WAIT1 (x FETCH_WAIT-1),
// DECODE, EXEC, WB, DONE. FETCH_WAIT must be >= 2.
module bitty_exec_core
  import bitty_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_REGS   = 8,
  parameter int FETCH_WAIT = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           instruction_in,
  output logic                        done1,
  output logic                        done2,
  output logic [DATA_W-1:0]           last_alu_result,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]           dbg_data
);

  localparam int WCNT_W = (FETCH_WAIT > 2) ? $clog2(FETCH_WAIT - 1) : 1;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [DATA_W-1:0]   ir_q, opa_q, opb_q, res_q, last_q;
  logic                done1_q, done2_q;

  logic [REG_W-1:0]    rx_in, ry_in, rx_ir;
  logic [TYPE_W-1:0]   type_ir;
  logic [SEL_W-1:0]    sel_ir;
  logic [DATA_W-1:0]   alu_b, alu_y;
  logic                wr_en;

  // Operand register indices come straight from the fetch register in DECODE;
  // everything later in the instruction works from the latched IR.
  assign rx_in   = instruction_in[RX_LSB +: REG_W];
  assign ry_in   = instruction_in[RY_LSB +: REG_W];
  assign rx_ir   = ir_q[RX_LSB +: REG_W];
  assign type_ir = ir_q[TYPE_LSB +: TYPE_W];
  assign sel_ir  = ir_q[SEL_LSB +: SEL_W];

  // Ry and imm8 overlap in the encoding, so the choice is made from IR in EXEC.
  assign alu_b = (type_ir == TYPE_IMM) ? DATA_W'(ir_q[IMM_LSB +: IMM_W]) : opb_q;
  assign wr_en = (state_q == WB) && ((type_ir == TYPE_REG) || (type_ir == TYPE_IMM));

  bitty_alu #(.W(DATA_W)) u_alu (
    .a   (opa_q),
    .b   (alu_b),
    .sel (sel_ir),
    .y   (alu_y)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      WAIT0: begin
        state_d = WAIT1;
        wait_d  = '0;
      end
      WAIT1: begin
        if (wait_q == WCNT_W'(FETCH_WAIT - 2)) state_d = DECODE;
        else                                   wait_d  = wait_q + WCNT_W'(1);
      end
      DECODE:  state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = DONE;
      DONE:    state_d = WAIT0;
      default: state_d = WAIT0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= WAIT0;
      wait_q  <= '0;
      ir_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      last_q  <= '0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      done1_q <= (state_q == WB);
      done2_q <= (state_q == DONE);
      if (state_q == DECODE) begin
        ir_q  <= instruction_in;
        opa_q <= rf_q[rx_in];
        opb_q <= rf_q[ry_in];
      end
      if (state_q == EXEC) res_q <= alu_y;
      // Branch and reserved types leave both Rx and last_alu_result untouched.
      if (wr_en) begin
        rf_q[rx_ir] <= res_q;
        last_q      <= res_q;
      end
    end
  end

  assign done1           = done1_q;
  assign done2           = done2_q;
  assign last_alu_result = last_q;
  assign dbg_data        = rf_q[dbg_sel];

endmodule

// File: tb/tb_bitty_exec_core.sv
// Directed table-driven bench for bitty_exec_core.
module tb_bitty_exec_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instruction_in = 16'h0;
  logic        done1, done2;
  logic [15:0] last_alu_result, dbg_data;
  logic [2:0]  dbg_sel = 3'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  sel;
    logic [15:0] res;
    logic [15:0] rd;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  bitty_exec_core dut (
    .clk             (clk),
    .reset           (reset),
    .instruction_in  (instruction_in),
    .done1           (done1),
    .done2           (done2),
    .last_alu_result (last_alu_result),
    .dbg_sel         (dbg_sel),
    .dbg_data        (dbg_data)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge where the core sits in WAIT0; done1 must show on the
  // 5th following negedge and done2 on the 6th.
  task automatic run_vec(input int idx, input logic [15:0] instr, input logic [2:0] sel,
                         input logic [15:0] exp_res, input logic [15:0] exp_rd);
    int n;
    n = 0;
    instruction_in = instr;
    dbg_sel = sel;
    do begin
      @(negedge clk);
      n++;
    end while (!done1 && n < 20);
    check($sformatf("v%0d done1 latency", idx), 16'(n), 16'd5);
    check($sformatf("v%0d result", idx), last_alu_result, exp_res);
    @(negedge clk);
    check($sformatf("v%0d strobes d1d2", idx), {14'b0, done1, done2}, 16'h0001);
    check($sformatf("v%0d R%0d", idx, sel), dbg_data, exp_rd);
  endtask

  initial begin
    //             instr     dbg  result    reg
    vecs[0]  = '{16'h20A1, 3'd1, 16'h0005, 16'h0005}; // R1 += 5
    vecs[1]  = '{16'h20A1, 3'd1, 16'h000A, 16'h000A}; // R1 += 5
    vecs[2]  = '{16'h4061, 3'd2, 16'h0003, 16'h0003}; // R2 += 3
    vecs[3]  = '{16'h2404, 3'd1, 16'h0000, 16'h0000}; // R1 = R1 - R1
    vecs[4]  = '{16'h2141, 3'd1, 16'h000A, 16'h000A}; // R1 += 10
    vecs[5]  = '{16'h2804, 3'd1, 16'h0007, 16'h0007}; // R1 = R1 - R2
    vecs[6]  = '{16'h0012, 3'd1, 16'h0007, 16'h0007}; // branch: hold
    vecs[7]  = '{16'h281C, 3'd1, 16'h0001, 16'h0001}; // cmp 7 vs 3 -> 1
    vecs[8]  = '{16'h6025, 3'd3, 16'hFFFF, 16'hFFFF}; // R3 = 0 - 1
    vecs[9]  = '{16'h6021, 3'd3, 16'h0000, 16'h0000}; // R3 += 1 wraps
    vecs[10] = '{16'h6021, 3'd3, 16'h0001, 16'h0001}; // R3 += 1
    vecs[11] = '{16'h61F5, 3'd3, 16'h8000, 16'h8000}; // R3 <<= 15
    vecs[12] = '{16'h61F9, 3'd3, 16'h0001, 16'h0001}; // R3 >>= 15
    vecs[13] = '{16'h7FF1, 3'd3, 16'h00FE, 16'h00FE}; // R3 ^= 0xFF
    vecs[14] = '{16'h6808, 3'd3, 16'h0002, 16'h0002}; // R3 &= R2
    vecs[15] = '{16'h640C, 3'd3, 16'h0003, 16'h0003}; // R3 |= R1
    vecs[16] = '{16'h4C1C, 3'd2, 16'h0000, 16'h0000}; // cmp 3 vs 3 -> 0
    vecs[17] = '{16'h2C1C, 3'd1, 16'h0002, 16'h0002}; // cmp 1 vs 3 -> 2
    vecs[18] = '{16'h2C1F, 3'd1, 16'h0002, 16'h0002}; // reserved: NOP
    vecs[19] = '{16'h6C14, 3'd3, 16'h0018, 16'h0018}; // R3 <<= R3 (Rx==Ry)
    vecs[20] = '{16'h6015, 3'd3, 16'h0018, 16'h0018}; // R3 <<= 0

    // Reset held 3 cycles with junk on instruction_in
    repeat (3) begin
      instruction_in = 16'($urandom);
      @(negedge clk);
      check("reset done1", {15'b0, done1}, 16'h0000);
      check("reset done2", {15'b0, done2}, 16'h0000);
      check("reset result", last_alu_result, 16'h0000);
    end
    for (int s = 0; s < 8; s++) begin
      dbg_sel = 3'(s);
      #1;
      check($sformatf("reset R%0d", s), dbg_data, 16'h0000);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++)
      run_vec(i, vecs[i].instr, vecs[i].sel, vecs[i].res, vecs[i].rd);

    // Final register image
    for (int s = 0; s < 8; s++) begin
      logic [15:0] e;
      dbg_sel = 3'(s);
      #1;
      e = (s == 1) ? 16'h0002 : (s == 3) ? 16'h0018 : 16'h0000;
      check($sformatf("final R%0d", s), dbg_data, e);
    end

    // Reset asserted while the core is in EXEC for R4 += 1
    instruction_in = 16'h8021;
    dbg_sel = 3'd4;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst done1", {15'b0, done1}, 16'h0000);
    check("midrst done2", {15'b0, done2}, 16'h0000);
    check("midrst result", last_alu_result, 16'h0000);
    check("midrst R4", dbg_data, 16'h0000);
    dbg_sel = 3'd3;
    #1;
    check("midrst R3", dbg_data, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    run_vec(NV, 16'h8021, 3'd4, 16'h0001, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
